execute_stage_hs: RTL
=====================

# execute_stage_hs

Next-generation execute stage of the pipelined RISC-V core: a parametrised execute stage with valid/ready handshakes on both sides, a pipeline flush, and an optional iterative multiply/divide unit. It sits between decode and memory stages, replacing the free-running latch-based stage. Single-cycle ALU ops complete in one cycle; mul/div ops stall decode while iterating. All results leave through one registered output slot, which holds under back-pressure.

## Interface
- ALU_OP_W, 3, ALU opcode width (shared `alu` encoding, `alt` modifier)
- DATA_W, 32, datapath width; also sets mul/div iteration count
- IMM_W, 32, immediate width; must equal DATA_W
- ADDR_W, 32, register-file write-address width
- PC_W, 32, program-counter width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid_i / in_ready_o  in/out  1  decode-side handshake; transfer when both high
- has_imm_i, alu_alt_i, rf_we_i, mem_we_i, mem2rf_i, branch_i, check_eq_i  in  1 each  decoded controls
- alu_op_i  in  ALU_OP_W  ALU opcode
- md_i  in  1  select mul/div unit instead of ALU
- md_op_i  in  2  00 MUL (low), 01 MULHU (high), 10 DIVU, 11 REMU; all unsigned
- imm32_i  in  IMM_W  immediate; rf_data0_i, rf_data1_i  in  DATA_W  operands
- rf_waddr_i  in  ADDR_W; pc_plus1_i  in  PC_W
- flush_i  in  1  discard in-flight and held work
- out_valid_o / out_ready_i  out/in  1  memory-side handshake
- rf_we_o, mem_we_o, mem2rf_o, branch_o, check_eq_o  out  1  registered controls
- mem_wdata_o, alu_result_o  out  DATA_W; rf_waddr_o  out  ADDR_W; pc_branch_o  out  PC_W
- busy_o  out  1  mul/div unit not IDLE

## Operation
- src1 = has_imm_i ? imm32_i : rf_data1_i; pc_branch = pc_plus1_i + imm32_i (mod 2^PC_W); mem_wdata = rf_data1_i.
- in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i) && !flush_i.
- Output slot freed when out_valid_o && out_ready_i; held bit-stable while out_valid_o && !out_ready_i.
- md_i=0 accept: ALU result and all sidebands loaded into output slot same edge.
- md_i=1 accept: operands, md_op, all sidebands and pc_branch captured internally; FSM IDLE→ITER.
- FSM: IDLE; ITER (DATA_W cycles, 5-bit-wide-enough counter, one bit per cycle: shift-add multiply into 2·DATA_W product; restoring divide); DONE (waits for free slot, then loads slot, →IDLE).
- DIVU by 0: quotient all-ones; REMU by 0: remainder = dividend.
- flush_i: clears out_valid_o, forces FSM to IDLE, blocks accept that cycle; priority over every other event, including a simultaneous out_ready_i or DONE completion.

## Timing
- Reset (reset low, async): out_valid_o=0, busy_o=0, all data/control outputs 0, FSM IDLE, counter 0.
- ALU op: accepted at edge E0 → out_valid_o high after E0 (latency 1); back-to-back accept every cycle when out_ready_i=1.
- Mul/div: accepted E0 → ITER E1..E_DATA_W → DONE → slot loaded at E_(DATA_W+1) if free (latency DATA_W+1); in_ready_o low from E0 until slot loaded.
- Slot full at DONE: stays DONE, no result loss, loads on first edge where slot frees.
- Reset deasserted mid-operation: no partial result ever appears.

## Configuration
- EX_MULDIV_EN defined: mul/div unit, ITER/DONE states and busy_o behaviour as above.
- Undefined: no mul/div logic; md_i and md_op_i ignored (op executes on ALU); busy_o tied 0; FSM permanently IDLE.

## Test plan
- Reset low mid-stream → all outputs 0 immediately; first ALU add 5+7 after release gives alu_result_o=12 one cycle after accept.
- has_imm_i=1, imm32_i=0xFFFFFFFF, pc_plus1_i=0x10 → pc_branch_o=0x0F, mem_wdata_o=rf_data1_i.
- out_ready_i=0 for 3 cycles with out_valid_o=1 → outputs stable, in_ready_o=0, next op accepted on cycle out_ready_i rises.
- MUL 0xFFFFFFFF·2 → alu_result_o=0xFFFFFFFE; MULHU same → 0x00000001; out_valid_o exactly 33 edges after accept.
- DIVU 100/7 → 14, REMU → 2; DIVU 9/0 → 0xFFFFFFFF, REMU 9/0 → 9.
- flush_i at iteration 10 of DIVU and with held slot → out_valid_o=0, busy_o=0 next cycle, no result emitted, new op accepted following cycle.

Source files
------------

// File: rtl/execute_stage_hs.sv
// -----------------------------------------------------------------------------
// execute_stage_hs
//
// Execute stage of the pipelined RISC-V core with valid/ready handshakes on
// the decode side and the memory side. Single-cycle ALU ops are written into
// the one registered output slot on the accepting edge. With EX_MULDIV_EN
// defined, an iterative unsigned multiply/divide unit runs one bit per cycle
// (DATA_W cycles) and stalls decode until its result is loaded into the slot.
// Without EX_MULDIV_EN, md_i/md_op_i are ignored and every op uses the ALU.
//
// Ports
//   clk, reset          clock (rising edge), async active-low reset
//   in_valid_i/in_ready_o   decode-side handshake
//   has_imm_i, alu_alt_i, alu_op_i, rf_data0_i, rf_data1_i, imm32_i
//                       operands and ALU control (alt: SUB / SRA)
//   rf_we_i, mem_we_i, mem2rf_i, branch_i, check_eq_i, rf_waddr_i, pc_plus1_i
//                       sidebands carried to the output slot
//   md_i, md_op_i       mul/div select: 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   flush_i             drop in-flight and held work
//   out_valid_o/out_ready_i memory-side handshake
//   rf_we_o .. pc_branch_o  registered output slot
//   busy_o              mul/div unit not idle
//
// ALU opcodes: 0 ADD/SUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL/SRA, 6 OR, 7 AND
// -----------------------------------------------------------------------------
module execute_stage_hs #(
    parameter int ALU_OP_W = 3,
    parameter int DATA_W   = 32,
    parameter int IMM_W    = 32,
    parameter int ADDR_W   = 32,
    parameter int PC_W     = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                has_imm_i,
    input  logic                alu_alt_i,
    input  logic                rf_we_i,
    input  logic                mem_we_i,
    input  logic                mem2rf_i,
    input  logic                branch_i,
    input  logic                check_eq_i,
    input  logic [ALU_OP_W-1:0] alu_op_i,
    input  logic                md_i,
    input  logic [1:0]          md_op_i,
    input  logic [IMM_W-1:0]    imm32_i,
    input  logic [DATA_W-1:0]   rf_data0_i,
    input  logic [DATA_W-1:0]   rf_data1_i,
    input  logic [ADDR_W-1:0]   rf_waddr_i,
    input  logic [PC_W-1:0]     pc_plus1_i,
    input  logic                flush_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                rf_we_o,
    output logic                mem_we_o,
    output logic                mem2rf_o,
    output logic                branch_o,
    output logic                check_eq_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W-1:0]   alu_result_o,
    output logic [ADDR_W-1:0]   rf_waddr_o,
    output logic [PC_W-1:0]     pc_branch_o,
    output logic                busy_o
);

    localparam int SH_W = $clog2(DATA_W);
    // Sideband bundle: 5 control bits, store data, write address, branch target
    localparam int SB_W = 5 + DATA_W + ADDR_W + PC_W;

    logic                r_out_valid;
    logic [SB_W-1:0]     r_out_sb;
    logic [DATA_W-1:0]   r_result;

    logic [DATA_W-1:0]   w_src0;
    logic [DATA_W-1:0]   w_src1;
    logic [SH_W-1:0]     w_shamt;
    logic [PC_W-1:0]     w_pc_branch;
    logic [SB_W-1:0]     w_sb_in;
    logic [DATA_W-1:0]   w_alu;
    logic                w_slot_free;
    logic                w_idle;
    logic                w_accept;
    logic                w_md_sel;
    logic                w_alu_acc;
    logic                w_md_done;
    logic [DATA_W-1:0]   w_md_result;
    logic [SB_W-1:0]     w_md_sb;

    assign w_src0      = rf_data0_i;
    assign w_src1      = has_imm_i ? DATA_W'(imm32_i) : rf_data1_i;
    assign w_shamt     = w_src1[SH_W-1:0];
    assign w_pc_branch = pc_plus1_i + PC_W'(imm32_i);
    assign w_sb_in     = {rf_we_i, mem_we_i, mem2rf_i, branch_i, check_eq_i,
                          rf_data1_i, rf_waddr_i, w_pc_branch};

    assign w_slot_free = !r_out_valid || out_ready_i;
    assign in_ready_o  = w_idle && w_slot_free && !flush_i;
    assign w_accept    = in_valid_i && in_ready_o;
    assign w_alu_acc   = w_accept && !w_md_sel;

    always_comb begin
        w_alu = '0;
        case (alu_op_i)
            ALU_OP_W'(0): w_alu = alu_alt_i ? (w_src0 - w_src1) : (w_src0 + w_src1);
            ALU_OP_W'(1): w_alu = w_src0 << w_shamt;
            ALU_OP_W'(2): w_alu = {{(DATA_W-1){1'b0}}, ($signed(w_src0) < $signed(w_src1))};
            ALU_OP_W'(3): w_alu = {{(DATA_W-1){1'b0}}, (w_src0 < w_src1)};
            ALU_OP_W'(4): w_alu = w_src0 ^ w_src1;
            ALU_OP_W'(5): w_alu = alu_alt_i ? DATA_W'($signed(w_src0) >>> w_shamt)
                                            : (w_src0 >> w_shamt);
            ALU_OP_W'(6): w_alu = w_src0 | w_src1;
            ALU_OP_W'(7): w_alu = w_src0 & w_src1;
            default:      w_alu = '0;
        endcase
    end

`ifdef EX_MULDIV_EN
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_md_op;
    logic [DATA_W-1:0]   r_hi;    // product high half / partial remainder
    logic [DATA_W-1:0]   r_lo;    // multiplier -> product low half / dividend -> quotient
    logic [DATA_W-1:0]   r_b;     // multiplicand / divisor
    logic [SB_W-1:0]     r_md_sb;

    logic [DATA_W:0]     w_msum;
    logic [DATA_W:0]     w_shift;
    logic [DATA_W:0]     w_trial;

    assign w_md_sel    = md_i;
    assign w_idle      = (r_state == S_IDLE);
    assign busy_o      = !w_idle;
    assign w_md_done   = (r_state == S_DONE) && w_slot_free;
    // MUL/DIVU deliver the low register, MULHU/REMU the high one
    assign w_md_result = r_md_op[0] ? r_hi : r_lo;
    assign w_md_sb     = r_md_sb;

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // then shift {carry, hi, lo} right by one.
    assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    // Restoring-divide step: bring in the next dividend bit and trial-subtract.
    // A zero divisor always succeeds, giving all-ones quotient and remainder = dividend.
    assign w_shift = {r_hi, r_lo[DATA_W-1]};
    assign w_trial = w_shift - {1'b0, r_b};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_accept && md_i)
                        r_state <= S_ITER;
                end
                S_ITER: begin
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (w_slot_free)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Iteration datapath; only meaningful while the FSM is in ITER/DONE
    always_ff @(posedge clk) begin
        if (w_accept && md_i) begin
            r_md_op <= md_op_i;
            r_hi    <= '0;
            r_lo    <= md_op_i[1] ? w_src0 : w_src1;
            r_b     <= md_op_i[1] ? w_src1 : w_src0;
            r_md_sb <= w_sb_in;
        end else if (r_state == S_ITER) begin
            if (r_md_op[1]) begin
                if (!w_trial[DATA_W]) begin
                    r_hi <= w_trial[DATA_W-1:0];
                    r_lo <= {r_lo[DATA_W-2:0], 1'b1};
                end else begin
                    r_hi <= w_shift[DATA_W-1:0];
                    r_lo <= {r_lo[DATA_W-2:0], 1'b0};
                end
            end else begin
                r_hi <= w_msum[DATA_W:1];
                r_lo <= {w_msum[0], r_lo[DATA_W-1:1]};
            end
        end
    end
`else
    logic w_unused_md;

    assign w_unused_md = ^{md_i, md_op_i};
    assign w_md_sel    = 1'b0;
    assign w_idle      = 1'b1;
    assign busy_o      = 1'b0;
    assign w_md_done   = 1'b0;
    assign w_md_result = '0;
    assign w_md_sb     = '0;
`endif

    // Output slot: flush wins, then ALU accept, then mul/div completion, then drain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_sb    <= '0;
            r_result    <= '0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
        end else if (w_alu_acc) begin
            r_out_valid <= 1'b1;
            r_out_sb    <= w_sb_in;
            r_result    <= w_alu;
        end else if (w_md_done) begin
            r_out_valid <= 1'b1;
            r_out_sb    <= w_md_sb;
            r_result    <= w_md_result;
        end else if (w_slot_free) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid_o  = r_out_valid;
    assign alu_result_o = r_result;
    assign {rf_we_o, mem_we_o, mem2rf_o, branch_o, check_eq_o,
            mem_wdata_o, rf_waddr_o, pc_branch_o} = r_out_sb;

endmodule
